reg_wr_scoreboard: RTL and testbench

//  Parametrised successor of the 5->32 register-select decoder. Decodes the writeback

---
 rtl/reg_wr_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_reg_wr_scoreboard.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wr_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_wr_scoreboard
//   Writeback address decoder plus in-flight destination scoreboard.
//   - Decodes wb_addr into a registered, single-active write-enable vector
//     (one-cold when ACT_LOW=1, one-hot when ACT_LOW=0).
//   - Tracks busy destination registers between issue and writeback and
//     reports RAW (source busy) and WAW (destination busy) hazards.
//   - Register 0 is hard-wired $zero unless ZERO_WE=1: never decoded, never
//     tracked, never stalls.
//   Optional feature macro: WB_BYPASS_EN
//     defined   : a register written back this cycle counts as not busy for
//                 raw_stall and the WAW term of iss_ready (regfile forwards).
//     undefined : hazards use the registered scoreboard only.
// -----------------------------------------------------------------------------
module reg_wr_scoreboard #(
  parameter  int unsigned ADDR_W  = 5,
  parameter  bit          ACT_LOW = 1'b1,
  parameter  bit          ZERO_WE = 1'b0,
  localparam int unsigned NREG    = 2 ** ADDR_W,
  localparam int unsigned CNT_W   = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // issue side
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              raw_stall,
  // writeback side
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic [NREG-1:0]   wr_en_vec,
  // scoreboard status
  output logic [NREG-1:0]   busy_vec,
  output logic [CNT_W-1:0]  busy_cnt,
  output logic              wb_err
);

  // Idle level of the write-enable vector: all ones for one-cold, zeros otherwise.
  localparam logic [NREG-1:0] WE_IDLE = {NREG{ACT_LOW}};

  // Registers that participate in decode and tracking; bit 0 drops out when
  // address 0 is the hard-wired zero register.
  localparam logic [NREG-1:0] TRACK_MASK =
    ZERO_WE ? {NREG{1'b1}} : {{(NREG-1){1'b1}}, 1'b0};

  // Update applied to busy_cnt on an edge.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_INC  = 2'b01,
    CNT_DEC  = 2'b10
  } cnt_op_e;

  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [NREG-1:0]  we_q;
  logic [NREG-1:0]  we_d;
  logic             err_q;
  logic             err_d;

  logic [NREG-1:0]  wb_onehot;    // decoded writeback, already masked and qualified
  logic [NREG-1:0]  iss_onehot;   // decoded issue destination, masked, unqualified
  logic [NREG-1:0]  busy_view;    // scoreboard as seen by the hazard checks
  logic [NREG-1:0]  set_vec;      // bit to set on an accepted issue
  logic             waw_hit;
  logic             accept;
  logic             clr_hit;      // writeback clears a genuinely busy register
  logic             spurious_wb;  // writeback to a tracked but idle register
  cnt_op_e          cnt_op;

  // Decode writeback and issue addresses into masked one-hot vectors.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wb_onehot  = '0;
    iss_onehot = '0;
    if (wb_valid) begin
      wb_onehot[wb_addr] = 1'b1;
    end
    iss_onehot[iss_addr] = 1'b1;
    wb_onehot  = wb_onehot  & TRACK_MASK;
    iss_onehot = iss_onehot & TRACK_MASK;
  end

  // Scoreboard view for hazard detection; with the bypass, a register being
  // written back this cycle is already considered free.
  always_comb begin
`ifdef WB_BYPASS_EN
    busy_view = busy_q & ~wb_onehot & TRACK_MASK;
`else
    busy_view = busy_q & TRACK_MASK;
`endif
  end

  // Hazard checks and issue handshake.
  always_comb begin
    raw_stall = busy_view[rs_addr] | busy_view[rt_addr];
    waw_hit   = busy_view[iss_addr];
    iss_ready = iss_valid & ~waw_hit & ~raw_stall;
    accept    = iss_valid & iss_ready;
  end

  // Next-state for scoreboard, counter, sticky error and decoded enables.
  always_comb begin
    set_vec     = accept ? iss_onehot : '0;
    clr_hit     = |(wb_onehot & busy_q);
    spurious_wb = (|wb_onehot) & ~clr_hit;

    // Clear first, then set, so a same-address accept and writeback leaves
    // the register busy.
    busy_d = (busy_q & ~wb_onehot) | set_vec;

    // An accept always targets a clear bit, so the counter can never wrap.
    cnt_op = CNT_HOLD;
    unique case ({clr_hit, |set_vec})
      2'b01:   cnt_op = CNT_INC;
      2'b10:   cnt_op = CNT_DEC;
      default: cnt_op = CNT_HOLD;
    endcase

    cnt_d = cnt_q;
    unique case (cnt_op)
      CNT_INC: cnt_d = cnt_q + CNT_W'(1);
      CNT_DEC: cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q | spurious_wb;

    // Writes to untracked paths still decode; $zero writes stay idle.
    we_d = ACT_LOW ? ~wb_onehot : wb_onehot;
  end

  // State registers with asynchronous reset; in-flight work is dropped.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      we_q   <= WE_IDLE;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      we_q   <= we_d;
    end
  end

  assign busy_vec  = busy_q;
  assign busy_cnt  = cnt_q;
  assign wb_err    = err_q;
  assign wr_en_vec = we_q;

endmodule

// File: tb/tb_reg_wr_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_wr_scoreboard
//   Directed bench for reg_wr_scoreboard with ADDR_W=5, ACT_LOW=1, ZERO_WE=0.
//   Honours WB_BYPASS_EN when the same macro is defined for the build.
// -----------------------------------------------------------------------------
module tb_reg_wr_scoreboard;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NREG    = 32;
  localparam bit          ACT_LOW = 1'b1;
  localparam bit          ZERO_WE = 1'b0;
`ifdef WB_BYPASS_EN
  localparam bit          BYPASS  = 1'b1;
`else
  localparam bit          BYPASS  = 1'b0;
`endif
  localparam logic [NREG-1:0] WE_IDLE = {NREG{ACT_LOW}};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic              raw_stall;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [NREG-1:0]   wr_en_vec;
  logic [NREG-1:0]   busy_vec;
  logic [ADDR_W:0]   busy_cnt;
  logic              wb_err;

  int checks = 0;
  int errors = 0;

  reg_wr_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ACT_LOW (ACT_LOW),
    .ZERO_WE (ZERO_WE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .raw_stall (raw_stall),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wr_en_vec (wr_en_vec),
    .busy_vec  (busy_vec),
    .busy_cnt  (busy_cnt),
    .wb_err    (wb_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0;
    iss_addr  = '0;
    rs_addr   = '0;
    rt_addr   = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Power-on reset: outputs take reset values without a clock edge.
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (wr_en_vec !== WE_IDLE) begin
      errors++; $display("FAIL reset_wr_en got %h want %h", wr_en_vec, WE_IDLE);
    end
    checks++;
    if (busy_vec !== '0) begin
      errors++; $display("FAIL reset_busy got %h want 0", busy_vec);
    end
    checks++;
    if (busy_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt got %0d want 0", busy_cnt);
    end
    checks++;
    if (wb_err !== 1'b0) begin
      errors++; $display("FAIL reset_wb_err got %b want 0", wb_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Every address decodes to exactly its own active bit one cycle later.
  task automatic test_decode_sweep();
    logic [NREG-1:0] exp_vec;
    for (int a = 0; a < NREG; a++) begin
      wb_valid = 1'b1;
      wb_addr  = ADDR_W'(a);
      tick();
      exp_vec = '0;
      if (a != 0) exp_vec[a] = 1'b1;
      if (ACT_LOW) exp_vec = ~exp_vec;
      checks++;
      if (wr_en_vec !== exp_vec) begin
        errors++; $display("FAIL decode_addr%0d got %h want %h", a, wr_en_vec, exp_vec);
      end
    end
    wb_valid = 1'b0;
    tick();
    checks++;
    if (wr_en_vec !== WE_IDLE) begin
      errors++; $display("FAIL decode_idle got %h want %h", wr_en_vec, WE_IDLE);
    end
    // Writebacks to 1..31 hit idle registers.
    checks++;
    if (wb_err !== 1'b1) begin
      errors++; $display("FAIL decode_spurious_err got %b want 1", wb_err);
    end
    do_reset();
  endtask

  // Read-after-write stall set by an issue, cleared by its writeback.
  task automatic test_raw();
    iss_valid = 1'b1;
    iss_addr  = 5'd8;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL raw_issue_ready got %b want 1", iss_ready);
    end
    tick();
    iss_valid = 1'b0;
    rs_addr   = 5'd8;
    #1;
    checks++;
    if (raw_stall !== 1'b1) begin
      errors++; $display("FAIL raw_rs_stall got %b want 1", raw_stall);
    end
    rs_addr = 5'd0;
    rt_addr = 5'd8;
    #1;
    checks++;
    if (raw_stall !== 1'b1) begin
      errors++; $display("FAIL raw_rt_stall got %b want 1", raw_stall);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd8;
    #1;
    checks++;
    if (raw_stall !== !BYPASS) begin
      errors++; $display("FAIL raw_wb_cycle got %b want %b", raw_stall, !BYPASS);
    end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++;
    if (raw_stall !== 1'b0) begin
      errors++; $display("FAIL raw_after_wb got %b want 0", raw_stall);
    end
    checks++;
    if (busy_cnt !== 6'd0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL raw_final got cnt=%0d err=%b want cnt=0 err=0", busy_cnt, wb_err);
    end
    idle_inputs();
  endtask

  // Write-after-write: a busy destination blocks the issue.
  task automatic test_waw();
    iss_valid = 1'b1;
    iss_addr  = 5'd5;
    tick();
    #1;
    checks++;
    if (iss_ready !== 1'b0) begin
      errors++; $display("FAIL waw_ready got %b want 0", iss_ready);
    end
    tick();
    checks++;
    if (busy_cnt !== 6'd1) begin
      errors++; $display("FAIL waw_cnt got %0d want 1", busy_cnt);
    end
    checks++;
    if (busy_vec !== 32'h0000_0020) begin
      errors++; $display("FAIL waw_busy got %h want 00000020", busy_vec);
    end
    iss_valid = 1'b0;
    wb_valid  = 1'b1;
    wb_addr   = 5'd5;
    tick();
    idle_inputs();
  endtask

  // Accept and writeback in the same cycle, same and different addresses.
  task automatic test_collision();
    do_reset();
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    tick();
    wb_valid = 1'b1;
    wb_addr  = 5'd9;
    #1;
    checks++;
    if (iss_ready !== BYPASS) begin
      errors++; $display("FAIL coll_same_ready got %b want %b", iss_ready, BYPASS);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (busy_vec !== (BYPASS ? 32'h0000_0200 : 32'h0)) begin
      errors++; $display("FAIL coll_same_busy got %h", busy_vec);
    end
    checks++;
    if (busy_cnt !== (BYPASS ? 6'd1 : 6'd0)) begin
      errors++; $display("FAIL coll_same_cnt got %0d want %0d", busy_cnt, BYPASS);
    end
    checks++;
    if (wb_err !== 1'b0) begin
      errors++; $display("FAIL coll_same_err got %b want 0", wb_err);
    end
    checks++;
    if (wr_en_vec !== 32'hFFFF_FDFF) begin
      errors++; $display("FAIL coll_same_we got %h want fffffdff", wr_en_vec);
    end

    // Different addresses: register 4 retires while 6 issues.
    do_reset();
    iss_valid = 1'b1;
    iss_addr  = 5'd4;
    tick();
    iss_addr = 5'd6;
    wb_valid = 1'b1;
    wb_addr  = 5'd4;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL coll_diff_ready got %b want 1", iss_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (busy_vec !== 32'h0000_0040 || busy_cnt !== 6'd1) begin
      errors++; $display("FAIL coll_diff got busy=%h cnt=%0d want 00000040 1", busy_vec, busy_cnt);
    end

    // Same address but idle: issue sets it, writeback is spurious.
    iss_valid = 1'b1;
    iss_addr  = 5'd7;
    wb_valid  = 1'b1;
    wb_addr   = 5'd7;
    tick();
    idle_inputs();
    checks++;
    if (busy_vec !== 32'h0000_00C0 || busy_cnt !== 6'd2 || wb_err !== 1'b1) begin
      errors++; $display("FAIL coll_idle got busy=%h cnt=%0d err=%b want 000000c0 2 1",
                         busy_vec, busy_cnt, wb_err);
    end
  endtask

  // Fill the scoreboard, retire one register, then retire it again.
  task automatic test_fill();
    do_reset();
    for (int a = 1; a < NREG; a++) begin
      iss_valid = 1'b1;
      iss_addr  = ADDR_W'(a);
      tick();
    end
    iss_valid = 1'b0;
    checks++;
    if (busy_cnt !== 6'd31 || busy_vec !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL fill got busy=%h cnt=%0d want fffffffe 31", busy_vec, busy_cnt);
    end
    // $zero is always ready and never tracked.
    iss_valid = 1'b1;
    iss_addr  = 5'd0;
    #1;
    checks++;
    if (iss_ready !== 1'b1) begin
      errors++; $display("FAIL fill_zero_ready got %b want 1", iss_ready);
    end
    tick();
    iss_valid = 1'b0;
    checks++;
    if (busy_cnt !== 6'd31) begin
      errors++; $display("FAIL fill_zero_cnt got %0d want 31", busy_cnt);
    end
    wb_valid = 1'b1;
    wb_addr  = 5'd3;
    tick();
    checks++;
    if (busy_cnt !== 6'd30 || wb_err !== 1'b0) begin
      errors++; $display("FAIL fill_wb1 got cnt=%0d err=%b want 30 0", busy_cnt, wb_err);
    end
    tick();
    wb_valid = 1'b0;
    checks++;
    if (busy_cnt !== 6'd30 || wb_err !== 1'b1) begin
      errors++; $display("FAIL fill_wb2 got cnt=%0d err=%b want 30 1", busy_cnt, wb_err);
    end
    tick();
    tick();
    checks++;
    if (wb_err !== 1'b1 || busy_vec !== 32'hFFFF_FFF6) begin
      errors++; $display("FAIL fill_sticky got err=%b busy=%h want 1 fffffff6", wb_err, busy_vec);
    end
    rt_addr = 5'd3;
    #1;
    checks++;
    if (raw_stall !== 1'b0) begin
      errors++; $display("FAIL fill_rt_free got %b want 0", raw_stall);
    end
    rt_addr = 5'd4;
    #1;
    checks++;
    if (raw_stall !== 1'b1) begin
      errors++; $display("FAIL fill_rt_busy got %b want 1", raw_stall);
    end
  endtask

  // Reset asserted mid-stream, off the clock edge, with work in flight.
  task automatic test_reset_async();
    iss_valid = 1'b1;
    iss_addr  = 5'd3;
    wb_valid  = 1'b1;
    wb_addr   = 5'd5;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en_vec !== 32'hFFFF_FFFF || busy_vec !== '0) begin
      errors++; $display("FAIL areset_vec got we=%h busy=%h want ffffffff 0", wr_en_vec, busy_vec);
    end
    checks++;
    if (busy_cnt !== '0 || wb_err !== 1'b0) begin
      errors++; $display("FAIL areset_cnt got cnt=%0d err=%b want 0 0", busy_cnt, wb_err);
    end
    tick();
    checks++;
    if (busy_vec !== '0 || wr_en_vec !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL areset_hold got busy=%h we=%h", busy_vec, wr_en_vec);
    end
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_raw();
    test_waw();
    test_collision();
    test_fill();
    test_reset_async();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
